cpu_clock_ctrl: RTL and testbench
=================================

# cpu_clock_ctrl

Parametrised run/step controller for the CPU core, driven from the 50 MHz board clock. Produces a one-cycle `step_en` pulse that the datapath and controlpath use as a clock enable, replacing the ad-hoc slow-clock mux with a single clock domain. Supports free-run, power-of-two divided, debounced single-step and N-step burst modes. A step counter is exposed for the HEX debug display.

## Interface
- `DIV_W`, 27: free-running divider counter width.
- `SEL_W`, 5: width of `div_sel`; requires 2^SEL_W ≥ DIV_W.
- `CNT_W`, 16: width of the step counter and burst length.
- `PC_W`, 16: PC width for breakpoint compare.
- `SYNC_STAGES`, 2: key synchroniser depth, ≥2.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable samples needed to accept a key level.

Ports:
- `CLOCK_50` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `mode` in 2: 0 free-run, 1 divided, 2 single-step, 3 burst.
- `div_sel` in SEL_W: divide exponent; period is 2^div_sel cycles; values ≥ DIV_W are clamped to DIV_W-1.
- `step_key` in 1: raw pushbutton, active-low, asynchronous.
- `burst_len` in CNT_W: steps per burst, sampled on the press event.
- `halt` in 1: synchronous level; forces `step_en`=0 while high. All other state is held.
- `pc` in PC_W, `bp_addr` in PC_W, `bp_en` in 1: breakpoint inputs. Present only with the macro defined.
- `step_en` out 1: registered one-cycle step pulse.
- `step_count` out CNT_W: total steps issued; wraps modulo 2^CNT_W.
- `busy` out 1: burst in progress.
- `bp_hit` out 1: sticky breakpoint flag. Present only with the macro defined.

## Operation
- Key path: `SYNC_STAGES` flops, then the debouncer. The debounced level changes only after `DEBOUNCE_CYCLES` consecutive samples differ from it. A press event is a debounced 1→0 transition and lasts one cycle.
- Divider: `div_cnt` increments every cycle and wraps. A divide tick occurs when the low `div_sel` bits of `div_cnt` are all zero. With `div_sel`=0, a tick occurs every cycle.
- FSM states: IDLE, RUN, BURST.
  - From any state, the next state is chosen from `mode`:
    - `mode`∈{0,1} → RUN.
    - `mode`∈{2,3} → IDLE, unless BURST is active with `mode`=3.
  - A change of `mode` aborts a burst and clears `remaining`.
  - RUN: the step request is 1 every cycle in mode 0, and equals the divide tick in mode 1.
  - IDLE, mode 2: a press event produces one step request.
  - IDLE, mode 3: a press event with `burst_len`≠0 loads `remaining`=`burst_len` and enters BURST. A press with `burst_len`=0 is ignored.
  - BURST: issues a step request every divide tick and decrements `remaining` on each issued step. Returns to IDLE after the step that makes `remaining` 0. Press events during BURST are ignored.
- `step_en` <= step request & ~`halt` & ~`bp_hit`.
- `step_count` increments on each cycle where `step_en` is 1.
- `busy` = (state==BURST).
- Steps suppressed by `halt` are not counted and do not decrement `remaining`. While halted, the burst resumes on the next tick after `halt` falls.

## Timing
- Reset values: `step_en`=0, `step_count`=0, `busy`=0, `bp_hit`=0, `div_cnt`=0, state IDLE, debounced key=1 (released), synchroniser flops=1.
- Press latency: the press event is produced `SYNC_STAGES`+`DEBOUNCE_CYCLES` cycles after a stable low edge; `step_en` follows 1 cycle after the press event.
- Divided mode: `step_en` is high exactly one cycle per 2^`div_sel` cycles. It is delayed 1 cycle from the tick because the output is registered.
- Reset asserted mid-burst returns all outputs to their reset values immediately; no partial step is issued.
- `halt` and a press event in the same cycle: the press is accepted (a burst still loads) but no step is issued that cycle. In mode 2 the single step is lost.

## Configuration
- `CPU_CLOCK_CTRL_BREAKPOINT_EN` defined:
  - `pc`, `bp_addr`, `bp_en` and `bp_hit` exist.
  - When `bp_en`=1, the compare is armed and `pc`==`bp_addr` in RUN or BURST, `bp_hit` sets on the next cycle and blocks further steps. A burst stays in BURST with `remaining` held.
  - A press event clears `bp_hit` and disarms the compare. This press issues no step in any mode. The compare re-arms once `pc`≠`bp_addr`.
- Macro undefined: the breakpoint ports and logic are absent and `bp_hit` is treated as 0.

## Test plan
- Reset with `mode`=0, release → `step_en`=1 from cycle 1 onward; `step_count`=10 after 10 cycles; `step_count` reaches 0xFFFF then wraps to 0.
- `mode`=1, `div_sel`=3 → `step_en` high 1 cycle in every 8; `halt` held for 16 cycles → 2 pulses missing, `step_count` unchanged during halt.
- `mode`=2, `DEBOUNCE_CYCLES`=4, key glitch low for 3 cycles → no step. Key low for 10 cycles → exactly one `step_en`, at sync+4+1 cycles.
- `mode`=3, `burst_len`=5, `div_sel`=1 → 5 pulses 2 cycles apart, `busy` high throughout, then IDLE. Switching `mode` to 2 after pulse 2 → burst aborted, `busy`=0.
- Assert `reset` during a burst with 3 steps remaining → outputs return to reset values asynchronously; no further pulses after release in mode 3.
- Macro defined, `mode`=0, `bp_en`=1, `bp_addr`=0x0004, bench `pc` increments on each step → steps stop with `pc`=4 and `bp_hit`=1. A press clears `bp_hit` and running resumes past 4 without re-hitting.

Source files
------------

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: run/step controller for the CPU core on the 50 MHz board clock.
// Produces a registered one-cycle step_en pulse that the core uses as a clock
// enable. The modes are free-run, power-of-two divided, debounced single-step
// and N-step burst.
//
// Optional feature macro: CPU_CLOCK_CTRL_BREAKPOINT_EN (adds pc/bp_addr/bp_en/bp_hit).
//
// Ports:
//   CLOCK_50   in   sole clock
//   reset      in   asynchronous, active-high
//   mode       in   0 free-run, 1 divided, 2 single-step, 3 burst
//   div_sel    in   divide exponent (period 2^div_sel), clamped to DIV_W-1
//   step_key   in   raw active-low pushbutton (asynchronous)
//   burst_len  in   steps per burst, sampled on the press event
//   halt       in   synchronous level, suppresses step_en while high
//   pc         in   core PC for breakpoint compare       (macro only)
//   bp_addr    in   breakpoint address                   (macro only)
//   bp_en      in   breakpoint enable                    (macro only)
//   step_en    out  one-cycle step pulse
//   step_count out  total steps issued, wraps
//   busy       out  burst in progress
//   bp_hit     out  sticky breakpoint flag               (macro only)
module cpu_clock_ctrl #(
  parameter int unsigned DIV_W           = 27,
  parameter int unsigned SEL_W           = 5,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned PC_W            = 16,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] div_sel,
  input  logic             step_key,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             halt,
`ifdef CPU_CLOCK_CTRL_BREAKPOINT_EN
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_en,
  output logic             bp_hit,
`endif
  output logic             step_en,
  output logic [CNT_W-1:0] step_count,
  output logic             busy
);

  if (SYNC_STAGES < 2 || PC_W < 1 || DEBOUNCE_CYCLES < 1 ||
      (64'd1 << SEL_W) < 64'(DIV_W)) begin : g_param_check
    $error("cpu_clock_ctrl: invalid parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BURST = 2'd2
  } state_e;

  localparam int unsigned      DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------- key path
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   key_s;
  logic                   key_db_q;
  logic [DB_W-1:0]        db_cnt_q;
  logic                   press_q;

  assign key_s = sync_q[SYNC_STAGES-1];

  // The debounced level flips once DEBOUNCE_CYCLES consecutive samples differ
  // from it; a flip to 0 is the one-cycle press event.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync_q   <= '1;
      key_db_q <= 1'b1;
      db_cnt_q <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], step_key};
      press_q <= 1'b0;
      if (key_s == key_db_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        key_db_q <= key_s;
        db_cnt_q <= '0;
        press_q  <= ~key_s;
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end
  end

  // ----------------------------------------------------------------- divider
  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_mask;
  logic [31:0]      sel_eff;
  logic             div_tick;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) div_cnt_q <= '0;
    else       div_cnt_q <= div_cnt_q + DIV_W'(1);
  end

  always_comb begin
    sel_eff = 32'(div_sel);
    if (sel_eff >= DIV_W) sel_eff = DIV_W - 1;
    div_mask = '0;
    for (int unsigned i = 0; i < DIV_W; i++) div_mask[i] = (i < sel_eff);
    div_tick = ((div_cnt_q & div_mask) == '0);
  end

  // -------------------------------------------------------------- core state
  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             step_en_q;
  logic [CNT_W-1:0] step_count_q;
  logic             step_req, step_en_d, press_use;
  logic             bp_hit_s, bp_match;

  // ------------------------------------------------------------- breakpoint
`ifdef CPU_CLOCK_CTRL_BREAKPOINT_EN
  logic bp_hit_q, bp_armed_q;

  always_comb begin
    bp_hit_s = bp_hit_q;
    bp_match = bp_en & bp_armed_q & (pc == bp_addr) &
               ((state_q == RUN) | (state_q == BURST));
  end

  // A press clears the flag and disarms; the compare re-arms once the PC has
  // moved off the breakpoint so the resumed run does not re-hit immediately.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      bp_hit_q   <= 1'b0;
      bp_armed_q <= 1'b1;
    end else if (press_q) begin
      bp_hit_q   <= 1'b0;
      bp_armed_q <= 1'b0;
    end else begin
      if (bp_match)        bp_hit_q   <= 1'b1;
      if (pc != bp_addr)   bp_armed_q <= 1'b1;
    end
  end

  assign bp_hit = bp_hit_q;
`else
  always_comb begin
    bp_hit_s = 1'b0;
    bp_match = 1'b0;
  end
`endif

  // ------------------------------------------------------------ state register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      step_en_q    <= 1'b0;
      step_count_q <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      step_en_q    <= step_en_d;
      step_count_q <= step_count_q + CNT_W'(step_en_d);
    end
  end

  // ------------------------------------------------------------- next state
  // Leaving BURST for any reason (mode change included) clears remaining.
  always_comb begin
    state_d     = IDLE;
    remaining_d = '0;
    if (!mode[1]) begin
      state_d = RUN;
    end else if (state_q == BURST && mode == 2'd3) begin
      state_d     = BURST;
      remaining_d = remaining_q;
      if (step_en_d) begin
        remaining_d = remaining_q - CNT_W'(1);
        if (remaining_q == CNT_W'(1)) state_d = IDLE;
      end
    end else if (state_q == IDLE && mode == 2'd3 && press_use && burst_len != '0) begin
      state_d     = BURST;
      remaining_d = burst_len;
    end
  end

  // ----------------------------------------------------------------- outputs
  // A press that clears a breakpoint is consumed by the clear. The live
  // match also gates the step so the core stops on the breakpoint PC.
  always_comb begin
    press_use = press_q & ~bp_hit_s;
    step_req  = 1'b0;
    case (mode)
      2'd0:    step_req = 1'b1;
      2'd1:    step_req = div_tick;
      2'd2:    step_req = (state_q == IDLE) & press_use;
      default: step_req = (state_q == BURST) & div_tick;
    endcase
    step_en_d = step_req & ~halt & ~bp_hit_s & ~bp_match;
    busy      = (state_q == BURST);
  end

  assign step_en    = step_en_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Self-checking bench for cpu_clock_ctrl: directed scenarios plus randomized
// stimulus, compared every cycle against a behavioural model.
module tb_cpu_clock_ctrl;
  localparam int unsigned DIV_W           = 6;
  localparam int unsigned SEL_W           = 5;
  localparam int unsigned CNT_W           = 10;
  localparam int unsigned PC_W            = 16;
  localparam int unsigned SYNC_STAGES     = 2;
  localparam int unsigned DEBOUNCE_CYCLES = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_BURST = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       mode;
  logic [SEL_W-1:0] div_sel;
  logic             step_key;
  logic [CNT_W-1:0] burst_len;
  logic             halt;
  logic             step_en;
  logic [CNT_W-1:0] step_count;
  logic             busy;
`ifdef CPU_CLOCK_CTRL_BREAKPOINT_EN
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  bp_addr;
  logic             bp_en;
  logic             bp_hit;
  // The bench core's PC advances once per issued step.
  assign pc = PC_W'(step_count);
`endif

  always #5 clk = ~clk;

  cpu_clock_ctrl #(
    .DIV_W          (DIV_W),
    .SEL_W          (SEL_W),
    .CNT_W          (CNT_W),
    .PC_W           (PC_W),
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .mode      (mode),
    .div_sel   (div_sel),
    .step_key  (step_key),
    .burst_len (burst_len),
    .halt      (halt),
`ifdef CPU_CLOCK_CTRL_BREAKPOINT_EN
    .pc        (pc),
    .bp_addr   (bp_addr),
    .bp_en     (bp_en),
    .bp_hit    (bp_hit),
`endif
    .step_en   (step_en),
    .step_count(step_count),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------ behavioural model
  int m_hist[$];   // raw key samples still travelling through the synchroniser
  int m_db, m_run, m_press, m_cyc, m_st, m_rem, m_en, m_cnt, m_bp, m_arm;

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < int'(SYNC_STAGES); i++) m_hist.push_back(1);
    m_db = 1; m_run = 0; m_press = 0; m_cyc = 0;
    m_st = M_IDLE; m_rem = 0; m_en = 0; m_cnt = 0;
    m_bp = 0; m_arm = 1;
  endtask

  task automatic model_step();
    int sel, tick, use_p, req, match, en, nst, nrem, s;
    sel   = (int'(div_sel) >= int'(DIV_W)) ? int'(DIV_W) - 1 : int'(div_sel);
    tick  = ((m_cyc % (1 << sel)) == 0);
    match = 0;
`ifdef CPU_CLOCK_CTRL_BREAKPOINT_EN
    match = bp_en && (m_arm != 0) && (pc == bp_addr) && (m_st != M_IDLE);
`endif
    use_p = m_press && !m_bp;
    case (mode)
      2'd0:    req = 1;
      2'd1:    req = tick;
      2'd2:    req = (m_st == M_IDLE) && use_p;
      default: req = (m_st == M_BURST) && tick;
    endcase
    en = req && !halt && !m_bp && !match;

    if (mode < 2) begin
      nst = M_RUN; nrem = 0;
    end else if (m_st == M_BURST && mode == 3) begin
      nrem = m_rem - en;
      nst  = (nrem == 0) ? M_IDLE : M_BURST;
    end else if (m_st == M_IDLE && mode == 3 && use_p && burst_len != 0) begin
      nst = M_BURST; nrem = int'(burst_len);
    end else begin
      nst = M_IDLE; nrem = 0;
    end

`ifdef CPU_CLOCK_CTRL_BREAKPOINT_EN
    if (m_press) begin
      m_bp = 0; m_arm = 0;
    end else begin
      if (match) m_bp = 1;
      if (pc != bp_addr) m_arm = 1;
    end
`endif

    m_st  = nst;
    m_rem = nrem;
    m_en  = en;
    m_cnt = (m_cnt + en) % (1 << CNT_W);

    s = m_hist.pop_front();
    m_hist.push_back(int'(step_key));
    m_press = 0;
    if (s != m_db) begin
      m_run++;
      if (m_run == int'(DEBOUNCE_CYCLES)) begin
        m_db = s; m_run = 0; m_press = (s == 0);
      end
    end else begin
      m_run = 0;
    end
    m_cyc = (m_cyc + 1) % (1 << DIV_W);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  task automatic cycle_check();
    chk("step_en", step_en, m_en);
    chk("step_count", step_count, m_cnt);
    chk("busy", busy, (m_st == M_BURST));
`ifdef CPU_CLOCK_CTRL_BREAKPOINT_EN
    chk("bp_hit", bp_hit, m_bp);
`endif
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      cycle_check();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, lat, found, hold;
    logic [CNT_W-1:0] c0;

    reset = 1'b1; mode = 2'd0; div_sel = '0; step_key = 1'b1;
    burst_len = '0; halt = 1'b0;
`ifdef CPU_CLOCK_CTRL_BREAKPOINT_EN
    bp_en = 1'b0; bp_addr = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_step_en", step_en, 0);
    chk("rst_step_count", step_count, 0);
    chk("rst_busy", busy, 0);

    // Free run: a step every cycle, counter wraps.
    reset = 1'b0;
    cyc(10);
    chk("run_count10", step_count, 10);
    found = 0;
    for (int i = 0; i < 1100 && found == 0; i++) begin
      cyc(1);
      if (step_count == {CNT_W{1'b1}}) found = 1;
    end
    chk("wrap_reached_max", found, 1);
    cyc(1);
    chk("wrap_to_zero", step_count, 0);

    // Divided mode and halt.
    mode = 2'd1; div_sel = 5'd3;
    cyc(8);
    n = 0;
    for (int i = 0; i < 64; i++) begin cyc(1); n += int'(step_en); end
    chk("div8_pulses", n, 8);
    c0 = step_count; halt = 1'b1;
    cyc(16);
    chk("halt_count_held", step_count, c0);
    halt = 1'b0;
    cyc(16);
    div_sel = 5'd31;  // clamps to DIV_W-1
    cyc(32);
    n = 0;
    for (int i = 0; i < 64; i++) begin cyc(1); n += int'(step_en); end
    chk("div_clamp_pulses", n, 64 >> (DIV_W - 1));
    div_sel = 5'd0;
    n = 0;
    for (int i = 0; i < 10; i++) begin cyc(1); n += int'(step_en); end
    chk("div0_pulses", n, 10);

    // Single step: glitch rejected, clean press steps once.
    mode = 2'd2;
    cyc(4);
    c0 = step_count; step_key = 1'b0;
    cyc(3);
    step_key = 1'b1;
    cyc(15);
    chk("glitch_no_step", step_count, c0);
    c0 = step_count; step_key = 1'b0; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (step_en && lat == 0) lat = i;
      if (i == 10) step_key = 1'b1;
    end
    chk("press_latency", lat, SYNC_STAGES + DEBOUNCE_CYCLES + 1);
    chk("press_one_step", step_count, c0 + 1'b1);

    // Burst of 5 at div_sel=1.
    mode = 2'd3; div_sel = 5'd1; burst_len = 10'd5;
    cyc(2);
    c0 = step_count; step_key = 1'b0; n = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      n += int'(step_en);
      if (i == 8) step_key = 1'b1;
    end
    chk("burst_pulses", n, 5);
    chk("burst_done_idle", busy, 0);

    // Burst aborted by a mode change after two pulses.
    c0 = step_count; step_key = 1'b0; found = 0;
    for (int i = 1; i <= 40 && found == 0; i++) begin
      cyc(1);
      if (i == 8) step_key = 1'b1;
      if (step_count == c0 + 2'd2) found = 1;
    end
    chk("abort_reached", found, 1);
    step_key = 1'b1; mode = 2'd2;
    cyc(1);
    chk("abort_busy", busy, 0);
    cyc(20);
    chk("abort_count", step_count, c0 + 2'd2);

    // Asynchronous reset with three burst steps still pending.
    mode = 2'd3; burst_len = 10'd6;
    cyc(2);
    c0 = step_count; step_key = 1'b0; found = 0;
    for (int i = 1; i <= 40 && found == 0; i++) begin
      cyc(1);
      if (i == 8) step_key = 1'b1;
      if (step_count == c0 + 2'd3) found = 1;
    end
    chk("reset_burst_reached", found, 1);
    step_key = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_step_en", step_en, 0);
    chk("async_rst_count", step_count, 0);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(20);
    chk("post_reset_no_steps", step_count, 0);

    // Randomized stimulus against the model.
    hold = 0;
    for (int blk = 0; blk < 60; blk++) begin
      mode      = 2'($urandom_range(0, 3));
      div_sel   = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      burst_len = 10'($urandom_range(0, 6));
      for (int i = 0; i < 40; i++) begin
        halt = ($urandom_range(0, 9) == 0);
        if (hold == 0) begin
          step_key = ~step_key;
          hold = $urandom_range(1, 12);
        end
        hold--;
        cyc(1);
      end
    end
    halt = 1'b0; step_key = 1'b1;
    cyc(20);

`ifdef CPU_CLOCK_CTRL_BREAKPOINT_EN
    // Breakpoint: run stops on pc==4, a press clears it and running resumes.
    reset = 1'b1; mode = 2'd0; bp_addr = 16'h0004; bp_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      cyc(1);
      if (bp_hit) found = 1;
    end
    chk("bp_hit_set", found, 1);
    cyc(5);
    chk("bp_stop_pc", pc, 16'h0004);
    chk("bp_no_step", step_en, 0);
    step_key = 1'b0;
    cyc(10);
    step_key = 1'b1;
    cyc(20);
    chk("bp_cleared", bp_hit, 0);
    chk("bp_resumed", (pc > 16'h0004), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
